// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types and constants for the multi-cache memory bus arbiter.
package cache_bus_arbiter_pkg;

   localparam int unsigned addr_width_c     = 32;
   localparam int unsigned word_width_c     = 32;
   localparam int unsigned dma_data_width_c = 2;
   localparam int unsigned wdata_width_c    = dma_data_width_c * word_width_c;

   // One request beat from a cache toward memory.
   typedef struct packed {
      logic                     we;
      logic [addr_width_c-1:0]  addr;
      logic [wdata_width_c-1:0] wdata;
   } cache_bus_pkt_t;

   // Bus ownership state: free, or locked to one cache for a whole block.
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } arb_state_e;

   // Number of bus beats needed to move one cache block.
   function automatic int unsigned beats_per_block(input int unsigned block_words,
                                                   input int unsigned beat_words);
      return block_words / beat_words;
   endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Cache-side and memory-side handshake bundle of the shared bus.
interface cache_bus_arbiter_if
   import cache_bus_arbiter_pkg::*;
#(
   parameter int unsigned num_caches_p = 2
);

   logic [num_caches_p-1:0]          cb_valid_i;
   logic [num_caches_p-1:0]          cb_yumi_o;
   cache_bus_pkt_t [num_caches_p-1:0] cb_pkt_i;

   logic                     mem_valid_o;
   logic                     mem_ready_i;
   logic                     mem_we_o;
   logic [addr_width_c-1:0]  mem_addr_o;
   logic [wdata_width_c-1:0] mem_wdata_o;

   logic                     mem_valid_i;
   logic [wdata_width_c-1:0] mem_data_i;
   logic [num_caches_p-1:0]  cb_valid_o;
   logic [wdata_width_c-1:0] cb_data_o;

   // Arbiter side.
   modport master (
      input  cb_valid_i, cb_pkt_i, mem_ready_i, mem_valid_i, mem_data_i,
      output cb_yumi_o, mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
             cb_valid_o, cb_data_o
   );

   // Caches and memory side.
   modport slave (
      output cb_valid_i, cb_pkt_i, mem_ready_i, mem_valid_i, mem_data_i,
      input  cb_yumi_o, mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
             cb_valid_o, cb_data_o
   );

endinterface

// File: rtl/cache_bus_arbiter_rr.sv
// Combinational round-robin pick: first request at or after ptr, cyclically.
module bus_rr_arbiter #(
   parameter int unsigned width_p    = 2,
   parameter int unsigned id_width_p = 1
)(
   input  logic [width_p-1:0]    req,
   input  logic [id_width_p-1:0] ptr,
   output logic [width_p-1:0]    grant,
   output logic [id_width_p-1:0] id
);

   int unsigned           idx;
   logic [id_width_p-1:0] sel;
   logic                  found;

   // Scan width_p slots starting at ptr; the first set request wins.
   always_comb begin
      grant = '0;
      id    = '0;
      found = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int unsigned k = 0; k < width_p; k++) begin
         idx = (32'(ptr) + k) % width_p;
         sel = id_width_p'(idx);
         if (!found && req[sel]) begin
            found      = 1'b1;
            grant[sel] = 1'b1;
            id         = sel;
         end
      end
   end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Locks the shared memory bus to one cache per block transfer, round-robin.
module cache_bus_arbiter
   import cache_bus_arbiter_pkg::*;
#(
   parameter  int unsigned num_caches_p     = 2,
   parameter  int unsigned block_width_p    = 8,
   parameter  int unsigned dma_data_width_p = dma_data_width_c,
   localparam int unsigned beats_lp     = beats_per_block(block_width_p, dma_data_width_p),
   localparam int unsigned id_width_lp  = (num_caches_p > 2) ? $clog2(num_caches_p) : 1,
   localparam int unsigned cnt_width_lp = $clog2(beats_lp + 1)
)(
   input  logic                   clk_i,
   input  logic                   nreset_i,
   cache_bus_arbiter_if.master    bus,
   output logic                   busy_o,
   output logic [id_width_lp-1:0] owner_o,
   output logic                   proto_err_o
);

   localparam logic [cnt_width_lp-1:0] beats_c    = cnt_width_lp'(beats_lp);
   localparam logic [id_width_lp-1:0]  last_id_c  = id_width_lp'(num_caches_p - 1);

   arb_state_e               state_q, state_d;
   logic [id_width_lp-1:0]   rr_ptr_q, rr_ptr_d;
   logic [id_width_lp-1:0]   owner_q, owner_d;
   logic [cnt_width_lp-1:0]  tx_q, tx_d;
   logic [cnt_width_lp-1:0]  rx_q, rx_d;
   logic                     we_q, we_d;
   logic                     err_q, err_d;

   logic [num_caches_p-1:0]  grant_c;
   logic [id_width_lp-1:0]   grant_id_c;
   cache_bus_pkt_t           owner_pkt_c;
   logic                     req_valid_c;
   logic                     fire_c;
   logic [num_caches_p-1:0]  yumi_c;
   logic [num_caches_p-1:0]  resp_valid_c;
   logic                     mem_we_c;
   logic [addr_width_c-1:0]  mem_addr_c;
   logic [wdata_width_c-1:0] mem_wdata_c;

   bus_rr_arbiter #(
      .width_p    (num_caches_p),
      .id_width_p (id_width_lp)
   ) u_rr (
      .req   (bus.cb_valid_i),
      .ptr   (rr_ptr_q),
      .grant (grant_c),
      .id    (grant_id_c)
   );

   // State, pointer, counters and sticky error.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         we_q     <= we_d;
         err_q    <= err_d;
      end
   end

   // Arbitration, beat forwarding, response routing and completion.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      tx_d         = tx_q;
      rx_d         = rx_q;
      we_d         = we_q;
      err_d        = err_q;
      req_valid_c  = 1'b0;
      fire_c       = 1'b0;
      yumi_c       = '0;
      resp_valid_c = '0;
      mem_we_c     = 1'b0;
      mem_addr_c   = '0;
      mem_wdata_c  = '0;
      owner_pkt_c  = bus.cb_pkt_i[owner_q];

      case (state_q)
         IDLE: begin
            if (|grant_c) begin
               owner_d = grant_id_c;
               state_d = ACTIVE;
            end
            if (bus.mem_valid_i) begin
               err_d = 1'b1;
            end
         end

         ACTIVE: begin
            req_valid_c = bus.cb_valid_i[owner_q] && (tx_q < beats_c);
            mem_we_c    = owner_pkt_c.we;
            mem_addr_c  = owner_pkt_c.addr;
            mem_wdata_c = owner_pkt_c.wdata;
            fire_c      = req_valid_c && bus.mem_ready_i;
            yumi_c[owner_q] = fire_c;
            if (fire_c) begin
               tx_d = tx_q + cnt_width_lp'(1);
               if (tx_q == '0) begin
                  we_d = owner_pkt_c.we;
               end
            end
            // Responses are only legal on a read with beats still owed back.
            if (bus.mem_valid_i) begin
               if (!we_q && (rx_q < tx_q)) begin
                  resp_valid_c[owner_q] = 1'b1;
                  rx_d = rx_q + cnt_width_lp'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            if ((tx_d == beats_c) && (we_d || (rx_d == beats_c))) begin
               state_d  = IDLE;
               tx_d     = '0;
               rx_d     = '0;
               rr_ptr_d = (owner_q == last_id_c) ? '0 : owner_q + id_width_lp'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.cb_yumi_o   = yumi_c;
   assign bus.mem_valid_o = req_valid_c;
   assign bus.mem_we_o    = mem_we_c;
   assign bus.mem_addr_o  = mem_addr_c;
   assign bus.mem_wdata_o = mem_wdata_c;
   assign bus.cb_valid_o  = resp_valid_c;
   assign bus.cb_data_o   = bus.mem_data_i;

   assign busy_o      = (state_q == ACTIVE);
   assign owner_o     = owner_q;
   assign proto_err_o = err_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed and randomized bench for cache_bus_arbiter with a transaction-level model.
module tb_cache_bus_arbiter;
   import cache_bus_arbiter_pkg::*;

   localparam int N     = 2;
   localparam int BEATS = 4;

   logic       clk = 1'b0;
   logic       nreset_i;
   logic       busy_o;
   logic [0:0] owner_o;
   logic       proto_err_o;

   always #5 clk = ~clk;

   cache_bus_arbiter_if #(.num_caches_p(N)) bus();

   cache_bus_arbiter #(
      .num_caches_p     (N),
      .block_width_p    (8),
      .dma_data_width_p (2)
   ) dut (
      .clk_i       (clk),
      .nreset_i    (nreset_i),
      .bus         (bus.master),
      .busy_o      (busy_o),
      .owner_o     (owner_o),
      .proto_err_o (proto_err_o)
   );

   int tests = 0;
   int fails = 0;

   // Cache behaviour: beats still to send per cache, stalls, request attributes.
   int          want[N];
   int          stall[N];
   bit          persist[N];
   bit          cfg_we[N];
   bit          req_we[N];
   logic [31:0] base[N];
   bit          rand_mode;
   int          ready_mode;
   int          resp_mode;

   // Observations.
   int   yumi_seen[N];
   int   cbv_seen[N];
   int   act_cyc;
   int   busy_cnt;
   int   glog[$];
   logic prev_busy;

   // Bus model: owner (-1 = bus free), beats sent/returned in the current block.
   int m_owner, m_last, m_ptr, m_sent, m_recvd;
   bit m_wr, m_err;

   logic [N-1:0] e_yumi, e_cbv;
   logic         e_mv, e_we;
   logic [31:0]  e_addr;
   logic [63:0]  e_wdata;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int want_total();
      int s = 0;
      for (int i = 0; i < N; i++) s += want[i];
      return s;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_last = 0; m_ptr = 0; m_sent = 0; m_recvd = 0;
      m_wr = 1'b0; m_err = 1'b0;
      for (int i = 0; i < N; i++) begin
         want[i] = 0; stall[i] = 0; persist[i] = 1'b0;
         yumi_seen[i] = 0; cbv_seen[i] = 0;
      end
      prev_busy = 1'b0;
      glog.delete();
   endtask

   task automatic drive();
      bit outstanding;
      for (int i = 0; i < N; i++) begin
         if (want[i] == 0 && (persist[i] || (rand_mode && $urandom_range(3) == 0))) begin
            want[i]   = BEATS;
            req_we[i] = rand_mode ? 1'($urandom_range(1)) : cfg_we[i];
            base[i]   = $urandom & 32'hFFFF_FFC0;
         end
         bus.cb_valid_i[i]     = (want[i] > 0) && (stall[i] == 0);
         bus.cb_pkt_i[i].we    = (rand_mode && want[i] != BEATS) ? 1'($urandom_range(1)) : req_we[i];
         bus.cb_pkt_i[i].addr  = base[i] + 32'((BEATS - want[i]) * 8);
         bus.cb_pkt_i[i].wdata = {$urandom, $urandom};
      end
      case (ready_mode)
         1:       bus.mem_ready_i = (act_cyc % 2 == 0);
         2:       bus.mem_ready_i = ($urandom_range(9) < 7);
         default: bus.mem_ready_i = 1'b1;
      endcase
      outstanding = (m_owner >= 0) && !m_wr && (m_recvd < m_sent);
      case (resp_mode)
         1:       bus.mem_valid_i = outstanding;
         2:       bus.mem_valid_i = outstanding && ($urandom_range(1) == 1);
         3:       bus.mem_valid_i = (m_owner >= 0);
         4:       bus.mem_valid_i = 1'b1;
         default: bus.mem_valid_i = 1'b0;
      endcase
      bus.mem_data_i = {$urandom, $urandom};
   endtask

   task automatic predict();
      e_yumi = '0; e_cbv = '0; e_mv = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
      if (m_owner >= 0) begin
         e_mv    = bus.cb_valid_i[m_owner] && (m_sent < BEATS);
         e_we    = bus.cb_pkt_i[m_owner].we;
         e_addr  = bus.cb_pkt_i[m_owner].addr;
         e_wdata = bus.cb_pkt_i[m_owner].wdata;
         if (e_mv && bus.mem_ready_i) e_yumi[m_owner] = 1'b1;
         if (bus.mem_valid_i && !m_wr && (m_recvd < m_sent)) e_cbv[m_owner] = 1'b1;
      end
   endtask

   task automatic check_outputs(input string ph);
      predict();
      chk({ph, "_yumi"},   128'(bus.cb_yumi_o),   128'(e_yumi));
      chk({ph, "_mvalid"}, 128'(bus.mem_valid_o), 128'(e_mv));
      chk({ph, "_mwe"},    128'(bus.mem_we_o),    128'(e_we));
      chk({ph, "_maddr"},  128'(bus.mem_addr_o),  128'(e_addr));
      chk({ph, "_mwdata"}, 128'(bus.mem_wdata_o), 128'(e_wdata));
      chk({ph, "_cbv"},    128'(bus.cb_valid_o),  128'(e_cbv));
      chk({ph, "_cbdata"}, 128'(bus.cb_data_o),   128'(bus.mem_data_i));
      chk({ph, "_busy"},   128'(busy_o),          128'(m_owner >= 0));
      chk({ph, "_owner"},  128'(owner_o),         128'(m_last));
      chk({ph, "_err"},    128'(proto_err_o),     128'(m_err));
      for (int i = 0; i < N; i++) begin
         if (bus.cb_yumi_o[i]) yumi_seen[i]++;
         if (bus.cb_valid_o[i]) cbv_seen[i]++;
      end
      if (busy_o === 1'b1) busy_cnt++;
      if (busy_o === 1'b1 && prev_busy !== 1'b1) glog.push_back(int'(owner_o));
      prev_busy = busy_o;
   endtask

   task automatic update();
      int pick;
      int o;
      int c;
      if (m_owner < 0) begin
         pick = -1;
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (pick < 0 && bus.cb_valid_i[c]) pick = c;
         end
         if (pick >= 0) begin
            m_owner = pick; m_last = pick; m_sent = 0; m_recvd = 0;
         end
         if (bus.mem_valid_i) m_err = 1'b1;
      end else begin
         o = m_owner;
         act_cyc++;
         if (e_yumi != '0) begin
            if (m_sent == 0) m_wr = bus.cb_pkt_i[o].we;
            m_sent++;
            want[o]--;
         end
         if (bus.mem_valid_i) begin
            if (e_cbv != '0) m_recvd++;
            else m_err = 1'b1;
         end
         if (m_sent == BEATS && (m_wr || m_recvd == BEATS)) begin
            m_owner = -1; m_ptr = (o + 1) % N; m_sent = 0; m_recvd = 0;
         end
      end
   endtask

   // One clock: drive after the falling edge, check, then advance the model.
   task automatic cycle(input string ph);
      drive();
      #1;
      check_outputs(ph);
      @(posedge clk);
      update();
      for (int i = 0; i < N; i++) if (stall[i] > 0) stall[i]--;
      @(negedge clk);
   endtask

   task automatic do_reset();
      nreset_i = 1'b0;
      bus.cb_valid_i = '0; bus.cb_pkt_i = '0; bus.mem_ready_i = 1'b0;
      bus.mem_valid_i = 1'b0; bus.mem_data_i = '0;
      model_reset();
      rand_mode = 1'b0; ready_mode = 0; resp_mode = 0; act_cyc = 0; busy_cnt = 0;
      @(negedge clk);
      #1 check_outputs("rst");
      @(negedge clk);
      nreset_i = 1'b1;
   endtask

   task automatic run_until_quiet(input string tag, input int max_cyc);
      bit quiet = 1'b0;
      for (int c = 0; c < max_cyc && !quiet; c++) begin
         cycle(tag);
         quiet = (m_owner < 0) && (want_total() == 0);
      end
      chk({tag, "_done"}, 128'(quiet), 128'(1));
   endtask

   task automatic run_until_yumi(input string tag, input int idx, input int n, input int max_cyc);
      for (int c = 0; c < max_cyc && yumi_seen[idx] < n; c++) cycle(tag);
      chk({tag, "_reach"}, 128'(yumi_seen[idx]), 128'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_order[5];
      exp_order = '{0, 1, 0, 1, 0};

      // 1: cache0 read block, one-cycle response latency; then rr_ptr=1 shows.
      do_reset();
      want[0] = BEATS; req_we[0] = 1'b0; base[0] = 32'h100;
      resp_mode = 1;
      run_until_quiet("t1", 30);
      chk("t1_yumi0", 128'(yumi_seen[0]), 128'(4));
      chk("t1_cbv0",  128'(cbv_seen[0]),  128'(4));
      glog.delete();
      cfg_we[0] = 1'b1; cfg_we[1] = 1'b1;
      want[0] = BEATS; req_we[0] = 1'b1; want[1] = BEATS; req_we[1] = 1'b1;
      resp_mode = 0;
      run_until_quiet("t1b", 30);
      chk("t1_first_after", 128'(glog.size() > 0 ? glog[0] : -1), 128'(1));

      // 2: two persistent requesters alternate starting with cache0.
      do_reset();
      persist[0] = 1'b1; persist[1] = 1'b1;
      for (int c = 0; c < 80 && glog.size() < 5; c++) cycle("t2");
      chk("t2_grants", 128'(glog.size()), 128'(5));
      for (int k = 0; k < 5; k++)
         chk($sformatf("t2_order%0d", k), 128'(k < glog.size() ? glog[k] : -1), 128'(exp_order[k]));

      // 3: cache1 write with ready toggling.
      do_reset();
      want[1] = BEATS; req_we[1] = 1'b1;
      ready_mode = 1; act_cyc = 0; busy_cnt = 0;
      run_until_quiet("t3", 30);
      chk("t3_yumi1", 128'(yumi_seen[1]), 128'(4));
      chk("t3_busy",  128'(busy_cnt),     128'(7));
      chk("t3_cbv",   128'(cbv_seen[0] + cbv_seen[1]), 128'(0));

      // 4: owner stalls mid-block while cache1 waits.
      do_reset();
      want[0] = BEATS; req_we[0] = 1'b0; want[1] = BEATS; req_we[1] = 1'b1;
      resp_mode = 1;
      run_until_yumi("t4a", 0, 2, 20);
      stall[0] = 5;
      for (int c = 0; c < 5; c++) cycle("t4s");
      chk("t4_noyumi1", 128'(yumi_seen[1]), 128'(0));
      run_until_quiet("t4", 40);
      chk("t4_yumi0", 128'(yumi_seen[0]), 128'(4));
      chk("t4_yumi1", 128'(yumi_seen[1]), 128'(4));
      chk("t4_cbv0",  128'(cbv_seen[0]),  128'(4));
      chk("t4_order", 128'(glog.size() > 1 ? glog[1] : -1), 128'(1));

      // 5: stray responses in IDLE and with nothing outstanding.
      do_reset();
      resp_mode = 4;
      cycle("t5i");
      resp_mode = 0;
      cycle("t5j");
      chk("t5_err_idle", 128'(proto_err_o), 128'(1));
      do_reset();
      want[0] = BEATS; req_we[0] = 1'b0;
      resp_mode = 3;
      run_until_quiet("t5", 30);
      resp_mode = 0;
      for (int c = 0; c < 3; c++) cycle("t5h");
      chk("t5_err_held", 128'(proto_err_o), 128'(1));
      chk("t5_cbv0",     128'(cbv_seen[0]), 128'(4));

      // 6: asynchronous reset mid-read, then re-request from scratch.
      do_reset();
      want[0] = BEATS; req_we[0] = 1'b0;
      resp_mode = 1;
      run_until_yumi("t6a", 0, 2, 20);
      drive();
      #2 nreset_i = 1'b0;
      model_reset();
      #1 check_outputs("t6rst");
      @(negedge clk);
      nreset_i = 1'b1;
      want[0] = BEATS; req_we[0] = 1'b0;
      run_until_quiet("t6", 30);
      chk("t6_yumi0",  128'(yumi_seen[0]), 128'(4));
      chk("t6_cbv0",   128'(cbv_seen[0]),  128'(4));
      chk("t6_owner0", 128'(glog.size() > 0 ? glog[0] : -1), 128'(0));

      // 7: random traffic with a well-behaved memory.
      do_reset();
      rand_mode = 1'b1; ready_mode = 2; resp_mode = 2;
      for (int c = 0; c < 400; c++) cycle("t7");
      rand_mode = 1'b0;
      run_until_quiet("t7d", 200);
      chk("t7_err", 128'(proto_err_o), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
Shares the single cache-to-memory bus between num_caches_p caches at block granularity. Round-robin arbitration picks one requesting cache and locks the bus to it for a whole block transfer of beats_lp = block_width_p/dma_data_width_p request beats. For reads it also waits for the matching response beats. The block sits between the cache array and the memory port and implements the multi-cache path of the bus.

Parameters:
num_caches_p, 2, number of caches sharing the bus (>=2)
block_width_p, 8, words per cache block
dma_data_width_p, 2, words per bus beat; must divide block_width_p
beats_lp (local), block_width_p/dma_data_width_p, beats per block
id_width_lp (local), max(1,$clog2(num_caches_p)), owner ID width

Ports:
clk_i  in  1  clock
nreset_i  in  1  asynchronous active-low reset
cb_valid_i  in  num_caches_p  per-cache request beat valid
cb_yumi_o  out  num_caches_p  per-cache request beat consumed
cb_pkt_i  in  num_caches_p x cache_bus_pkt_width  per-cache packet {we, addr, wdata}
mem_valid_o  out  1  request beat valid to memory
mem_ready_i  in  1  memory accepts request beat
mem_we_o  out  1  owner packet we
mem_addr_o  out  32  owner packet addr
mem_wdata_o  out  dma_data_width_p*32  owner packet wdata
mem_valid_i  in  1  read response beat valid
mem_data_i  in  dma_data_width_p*32  read response data
cb_valid_o  out  num_caches_p  response valid, one-hot to the owner
cb_data_o  out  dma_data_width_p*32  mem_data_i, broadcast
busy_o  out  1  bus locked (state ACTIVE)
owner_o  out  id_width_lp  current or last owner ID
proto_err_o  out  1  sticky unexpected-response flag

Behaviour:
- Reset values (async on nreset_i low): state=IDLE, rr_ptr=0, owner=0, tx_cnt=0, rx_cnt=0, proto_err_o=0. All valid/yumi outputs 0 and busy_o=0.
- IDLE:
  - All outputs deasserted.
  - If any cb_valid_i is set, pick the first set bit at or after rr_ptr (cyclic), latch owner, go to ACTIVE next cycle. Arbitration costs one cycle.
  - mem_valid_i in IDLE: dropped, set proto_err_o.
- ACTIVE:
  - mem_valid_o = cb_valid_i[owner] & (tx_cnt<beats_lp).
  - mem_we_o, mem_addr_o and mem_wdata_o come combinationally from cb_pkt_i[owner].
  - cb_yumi_o[owner] = mem_valid_o & mem_ready_i. All other yumi bits are 0. On each yumi, tx_cnt++.
  - Transaction type is latched from we of the first accepted beat (tx_cnt==0). we on later beats is ignored.
  - Read: cb_valid_o[owner]=mem_valid_i while rx_cnt<tx_cnt, then rx_cnt++. Responses may overlap requests, and a request and a response may land in the same cycle. A response with rx_cnt==tx_cnt, or any response during a write, is dropped and sets proto_err_o.
  - Completion:
    - write: tx_cnt==beats_lp
    - read: tx_cnt==beats_lp and rx_cnt==beats_lp
    - On completion, next cycle: state=IDLE, counters=0, rr_ptr=(owner+1) mod num_caches_p.
  - If the owner drops cb_valid_i mid-block, the bus stays locked and stalls. There is no timeout or preemption.
  - Requests from other caches are held off (yumi=0) until the owner completes.
- Counters are $clog2(beats_lp+1) bits and never exceed beats_lp.
- cb_data_o = mem_data_i at all times.
- Reset mid-block returns to IDLE immediately. In-flight beats are abandoned and caches must re-request.
- proto_err_o clears only on reset.

Decomposition:
- cache_bus_pkt_t comes from the existing cache.svh macro.
- Add an arbiter state enum {IDLE, ACTIVE} and a beats-per-block constant function to the shared cache package.
- One sub-module, bus_rr_arbiter: combinational round-robin pick from a request vector and a pointer. It outputs a one-hot grant plus encoded ID.

Test Plan:
1. N=2, beats=4. Cache0 read at 0x100, mem_ready_i=1, responses one cycle after each beat -> 4 yumi to cache0, 4 cb_valid_o[0], busy_o low one cycle after the 4th response, rr_ptr=1.
2. Both caches valid at the same time from reset -> cache0 served first, then cache1. With both still valid, the next grants alternate 0,1,0.
3. Cache1 write of 4 beats with mem_ready_i toggling 1,0,1,0,... -> exactly 4 yumi over 7 cycles, mem_we_o=1, no cb_valid_o, return to IDLE.
4. Owner cache0 drops valid after 2 beats for 5 cycles while cache1 is valid -> cache1 gets no yumi, and cache0 finishes beats 3-4 on return.
5. mem_valid_i pulsed in IDLE, and a 5th response on a read -> data dropped, no cb_valid_o, proto_err_o=1 and held.
6. nreset_i low after 2 beats of a read -> all outputs 0 asynchronously. After release, cache0 is re-arbitrated from rr_ptr=0 and tx_cnt restarts at 0.
